move_sequencer: RTL and testbench

Queues discrete robot motion commands (forward distance, left/right pivot, U-turn) and plays them one at a time through the two wheel step controllers. It converts each command into per-wheel rotation degrees and directions, issues a one-cycle start to the step controllers, waits for their completion, and lets the motors settle before the next move. It sits between the maze-solving state machine and the stepctl pair, and owns `driver_sel` while any move is pending.

---
 rtl/maze_pkg.sv | 24 ++
 rtl/move_fifo.sv | 73 +++++++
 rtl/move_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_move_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared encodings for the maze robot motion path: command ops, sequencer
// states and wheel direction values.
package maze_pkg;

  typedef enum logic [1:0] {
    OP_FWD   = 2'b00,
    OP_LEFT  = 2'b01,
    OP_RIGHT = 2'b10,
    OP_UTURN = 2'b11
  } move_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_ARM    = 3'd3,
    ST_RUN    = 3'd4,
    ST_SETTLE = 3'd5
  } move_state_e;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/move_fifo.sv
// Synchronous command FIFO for move_sequencer; push and pop may coincide even
// when full, and flush empties it in one cycle.
module move_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic                   WF_CLK,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      cnt_r;
  logic             full_s;
  logic             empty_s;
  logic             pop_s;
  logic             push_s;

  assign full_s  = (cnt_r == (AW + 1)'(DEPTH));
  assign empty_s = (cnt_r == {(AW + 1){1'b0}});
  assign pop_s   = pop && !empty_s;
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign push_s  = push && (!full_s || pop_s);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {(AW + 1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {(AW + 1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (push_s && !pop_s) begin
        cnt_r <= cnt_r + (AW + 1)'(1);
      end else if (pop_s && !push_s) begin
        cnt_r <= cnt_r - (AW + 1)'(1);
      end
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge WF_CLK) begin
    if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = full_s;
  assign empty = empty_s;
  assign level = cnt_r;

endmodule

// File: rtl/move_sequencer.sv
// Plays queued motion commands through the two wheel step controllers.
// Optional RUN watchdog: define MOVE_TIMEOUT_EN.
module move_sequencer
  import maze_pkg::*;
#(
  parameter int               DEPTH       = 4,
  parameter int               DEG_W       = 16,
  parameter logic [DEG_W-1:0] TURN90_DEG  = 16'd180,
  parameter int               ARM_CYC     = 8,
  parameter int               SETTLE_CYC  = 2_000_000,
  parameter int               TIMEOUT_CYC = 500_000_000
) (
  input  logic                   WF_CLK,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [DEG_W-1:0]       cmd_arg,
  input  logic                   abort,
  input  logic                   step_busy,
  output logic                   step_start,
  output logic [DEG_W-1:0]       degreeL,
  output logic [DEG_W-1:0]       degreeR,
  output logic                   dirL,
  output logic                   dirR,
  output logic                   driver_sel,
  output logic [$clog2(DEPTH):0] level,
  output logic                   fault
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ARM_CYC < 1 || SETTLE_CYC < 1 ||
      TIMEOUT_CYC < 1) begin : g_param_check
    $error("move_sequencer: invalid parameter set");
  end

`ifdef MOVE_TIMEOUT_EN
  localparam int CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ?
                           ((TIMEOUT_CYC > ARM_CYC) ? TIMEOUT_CYC : ARM_CYC) :
                           ((SETTLE_CYC > ARM_CYC) ? SETTLE_CYC : ARM_CYC);
`else
  localparam int CNT_MAX = (SETTLE_CYC > ARM_CYC) ? SETTLE_CYC : ARM_CYC;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int FW    = DEG_W + 2;

  move_state_e      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             step_start_r;
  logic [DEG_W-1:0] deg_l_r;
  logic [DEG_W-1:0] deg_r_r;
  logic             dir_l_r;
  logic             dir_r_r;

  logic [FW-1:0]          fifo_rdata_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [$clog2(DEPTH):0] fifo_level_s;
  logic                   cmd_ready_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   flush_s;
  logic                   timeout_s;
  move_op_e               head_op_s;
  logic [DEG_W-1:0]       head_arg_s;
  logic [DEG_W-1:0]       ld_deg_s;
  logic                   ld_dir_l_s;
  logic                   ld_dir_r_s;

  assign cmd_ready_s = !fifo_full_s && !abort;
  assign push_s      = cmd_valid && cmd_ready_s;
  assign pop_s       = (state_r == ST_LOAD) && !fifo_empty_s && !flush_s;
  assign flush_s     = abort || timeout_s;

`ifdef MOVE_TIMEOUT_EN
  assign timeout_s = (state_r == ST_RUN) && step_busy && (cnt_r == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_s = 1'b0;
`endif

  move_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_move_fifo (
    .WF_CLK (WF_CLK),
    .rst_n  (rst_n),
    .push   (push_s),
    .pop    (pop_s),
    .flush  (flush_s),
    .wdata  ({cmd_op, cmd_arg}),
    .rdata  (fifo_rdata_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s),
    .level  (fifo_level_s)
  );

  assign head_op_s  = move_op_e'(fifo_rdata_s[DEG_W +: 2]);
  assign head_arg_s = fifo_rdata_s[DEG_W-1:0];

  // Translate the head command into per-wheel degrees and directions.
  always_comb begin
    ld_deg_s   = {DEG_W{1'b0}};
    ld_dir_l_s = DIR_FWD;
    ld_dir_r_s = DIR_FWD;
    case (head_op_s)
      OP_FWD: begin
        ld_deg_s = head_arg_s;
      end
      OP_LEFT: begin
        ld_deg_s   = TURN90_DEG;
        ld_dir_l_s = DIR_REV;
      end
      OP_RIGHT: begin
        ld_deg_s   = TURN90_DEG;
        ld_dir_r_s = DIR_REV;
      end
      OP_UTURN: begin
        ld_deg_s   = {TURN90_DEG[DEG_W-2:0], 1'b0};
        ld_dir_r_s = DIR_REV;
      end
      default: begin
        ld_deg_s = {DEG_W{1'b0}};
      end
    endcase
  end

  // Move state machine; one counter serves the ARM window, SETTLE and the RUN watchdog.
  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      step_start_r <= 1'b0;
      deg_l_r      <= {DEG_W{1'b0}};
      deg_r_r      <= {DEG_W{1'b0}};
      dir_l_r      <= 1'b0;
      dir_r_r      <= 1'b0;
    end else if (flush_s) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      step_start_r <= 1'b0;
      deg_l_r      <= {DEG_W{1'b0}};
      deg_r_r      <= {DEG_W{1'b0}};
      dir_l_r      <= 1'b0;
      dir_r_r      <= 1'b0;
    end else begin
      step_start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            state_r <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (!fifo_empty_s) begin
            deg_l_r <= ld_deg_s;
            deg_r_r <= ld_deg_s;
            dir_l_r <= ld_dir_l_s;
            dir_r_r <= ld_dir_r_s;
            state_r <= ST_START;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_START: begin
          step_start_r <= 1'b1;
          cnt_r        <= {CNT_W{1'b0}};
          state_r      <= ST_ARM;
        end
        ST_ARM: begin
          if (step_busy) begin
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_RUN;
          end else if (cnt_r == CNT_W'(ARM_CYC - 1)) begin
            // Controllers never went busy: treat as a zero-length move.
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_SETTLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!step_busy) begin
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_SETTLE;
          end else begin
`ifdef MOVE_TIMEOUT_EN
            cnt_r <= cnt_r + CNT_W'(1);
`else
            cnt_r <= cnt_r;
`endif
          end
        end
        ST_SETTLE: begin
          if (cnt_r == CNT_W'(SETTLE_CYC - 1)) begin
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= fifo_empty_s ? ST_IDLE : ST_LOAD;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MOVE_TIMEOUT_EN
  logic fault_r;

  // Sticky watchdog flag; only reset clears it.
  always_ff @(posedge WF_CLK or negedge rst_n) begin
    if (!rst_n) begin
      fault_r <= 1'b0;
    end else if (timeout_s) begin
      fault_r <= 1'b1;
    end
  end

  assign fault = fault_r;
`else
  assign fault = 1'b0;
`endif

  assign cmd_ready  = cmd_ready_s;
  assign step_start = step_start_r && !abort;
  assign degreeL    = deg_l_r;
  assign degreeR    = deg_r_r;
  assign dirL       = dir_l_r;
  assign dirR       = dir_r_r;
  assign driver_sel = (state_r != ST_IDLE) || !fifo_empty_s;
  assign level      = fifo_level_s;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: an event-level timeline model checked every
// cycle, plus hand-computed expectations per scenario.
`timescale 1ns/1ps
module tb_move_sequencer;

  localparam int DEPTH  = 4;
  localparam int ARM    = 8;
  localparam int SETTLE = 20;
  localparam int TMO    = 50;
`ifdef MOVE_TIMEOUT_EN
  localparam int LONG_BUSY = 40;
`else
  localparam int LONG_BUSY = 100;
`endif

  logic        WF_CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_arg = 16'd0;
  logic        abort = 1'b0;
  logic        step_busy = 1'b0;
  logic        cmd_ready, step_start, dirL, dirR, driver_sel, fault;
  logic [15:0] degreeL, degreeR;
  logic [2:0]  level;

  logic       f_push = 1'b0, f_pop = 1'b0, f_flush = 1'b0;
  logic [3:0] f_wdata = 4'd0;
  logic [3:0] f_rdata;
  logic       f_full, f_empty;
  logic [2:0] f_level;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  move_sequencer #(
    .DEPTH(DEPTH), .DEG_W(16), .TURN90_DEG(16'd180), .ARM_CYC(ARM),
    .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)
  ) dut (
    .WF_CLK(WF_CLK), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .step_busy(step_busy),
    .step_start(step_start), .degreeL(degreeL), .degreeR(degreeR), .dirL(dirL),
    .dirR(dirR), .driver_sel(driver_sel), .level(level), .fault(fault)
  );

  move_fifo #(.DEPTH(4), .WIDTH(4)) u_fifo (
    .WF_CLK(WF_CLK), .rst_n(rst_n), .push(f_push), .pop(f_pop), .flush(f_flush),
    .wdata(f_wdata), .rdata(f_rdata), .full(f_full), .empty(f_empty), .level(f_level)
  );

  always #5 WF_CLK = ~WF_CLK;
  always @(posedge WF_CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- timeline model ----------------
  typedef struct { logic [15:0] deg; logic dl; logic dr; } mv_t;
  mv_t pend_q[$];
  mv_t m_out;
  int  m_level, t_load, t_start, t_free, s_edge, r_edge;
  bit  moving, seen, m_start, m_fault;
  int  start_cyc_q[$];
  logic [17:0] start_val_q[$];

  function automatic mv_t to_move(input logic [1:0] op, input logic [15:0] arg);
    mv_t m;
    case (op)
      2'd0:    m = '{arg, 1'b0, 1'b0};
      2'd1:    m = '{16'd180, 1'b1, 1'b0};
      2'd2:    m = '{16'd180, 1'b0, 1'b1};
      default: m = '{16'd360, 1'b0, 1'b1};
    endcase
    return m;
  endfunction

  task automatic model_flush();
    pend_q.delete();
    m_level = 0; t_load = -1; t_start = -1; t_free = -1;
    moving = 0; seen = 0; m_start = 0;
    m_out = '{16'd0, 1'b0, 1'b0};
  endtask

  always @(negedge WF_CLK) begin : cmp
    int e, pl;
    bit acc, pop, to_flush, idle_b;
    if (!rst_n) begin
      model_flush();
      m_fault = 0;
      check("rst_step_start", step_start, 0);
      check("rst_level", level, 0);
      check("rst_degreeL", degreeL, 0);
      check("rst_dirs", {dirL, dirR}, 0);
      check("rst_driver_sel", driver_sel, 0);
      check("rst_fault", fault, 0);
      check("rst_cmd_ready", cmd_ready, !abort);
    end else begin
      check("step_start", step_start, m_start && !abort);
      check("level", level, m_level);
      check("cmd_ready", cmd_ready, (m_level < DEPTH) && !abort);
      check("driver_sel", driver_sel,
            moving || t_free >= 0 || t_load >= 0 || t_start >= 0 || m_level > 0);
      check("degreeL", degreeL, m_out.deg);
      check("degreeR", degreeR, m_out.deg);
      check("dirL", dirL, m_out.dl);
      check("dirR", dirR, m_out.dr);
      check("fault", fault, m_fault);
      if (step_start) begin
        start_cyc_q.push_back(cyc);
        start_val_q.push_back({degreeL, dirL, dirR});
      end
      // advance the model to the coming edge
      e = cyc + 1;
      if (abort) begin
        model_flush();
      end else begin
        pl = m_level;
        idle_b = !moving && t_free < 0 && t_load < 0 && t_start < 0;
        acc = cmd_valid && (m_level < DEPTH);
        pop = (t_load == e);
        to_flush = 0;
        if (moving && e > s_edge) begin
          if (step_busy) begin
            if (!seen) begin
              seen = 1; r_edge = e;
            end
`ifdef MOVE_TIMEOUT_EN
            else if (e - r_edge == TMO) to_flush = 1;
`endif
          end else if (seen || e - s_edge == ARM) begin
            moving = 0; t_free = e + SETTLE;
          end
        end
        if (to_flush) begin
          model_flush();
          m_fault = 1;
        end else begin
          if (acc) pend_q.push_back(to_move(cmd_op, cmd_arg));
          m_start = (t_start == e);
          if (m_start) begin
            moving = 1; seen = 0; s_edge = e; t_start = -1;
          end
          if (pop) begin
            m_out = pend_q.pop_front(); t_load = -1; t_start = e + 1;
          end
          m_level = pl + int'(acc) - int'(pop);
          if (t_free == e) begin
            t_free = -1;
            if (pl > 0) t_load = e + 1;
          end else if (idle_b && pl > 0) begin
            t_load = e + 1;
          end
        end
      end
    end
  end

  // ---------------- step controller stand-in ----------------
  int resp_delay = 2;
  int resp_len = LONG_BUSY;
  bit resp_en = 1;

  initial forever begin
    @(posedge WF_CLK); #1;
    if (step_start && resp_en) begin
      repeat (resp_delay - 1) begin @(posedge WF_CLK); #1; end
      step_busy = 1'b1;
      repeat (resp_len) begin @(posedge WF_CLK); #1; end
      step_busy = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge WF_CLK); #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [15:0] arg);
    int n = 0;
    cmd_op = op; cmd_arg = arg; cmd_valid = 1'b1;
    while (!cmd_ready && n < 500) begin tick(); n++; end
    if (!cmd_ready) check("push_wait_expired", 0, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(output int s);
    int n = 0;
    s = -1;
    while (n < 500) begin
      tick(); n++;
      if (step_start) begin s = cyc; break; end
    end
    if (s < 0) check("start_wait_expired", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((driver_sel || step_busy) && n < 2000) begin tick(); n++; end
    if (driver_sel || step_busy) check("idle_wait_expired", 0, 1);
  endtask

  initial begin : wdog
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a0, s0, s1, base, n;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("lit_reset_ready", cmd_ready, 1);
    check("lit_reset_level", level, 0);

    // forward move, second command queued while the first runs
    push(2'd0, 16'd360);
    a0 = cyc;
    wait_start(s0);
    check("lit_fwd_latency", s0 - a0, 3);
    check("lit_fwd_degL", degreeL, 360);
    check("lit_fwd_degR", degreeR, 360);
    check("lit_fwd_dirs", {dirL, dirR}, 0);
    push(2'd0, 16'd90);
    wait_start(s1);
    check("lit_fwd_gap", s1 - s0, LONG_BUSY + 2 + SETTLE + 2);
    check("lit_fwd2_deg", degreeL, 90);
    wait_idle();

    // three turns back to back
    resp_len = 5;
    base = start_cyc_q.size();
    push(2'd2, 16'd7);
    push(2'd1, 16'd7);
    push(2'd3, 16'd7);
    wait_idle();
    check("lit_turn_count", start_cyc_q.size() - base, 3);
    if (start_cyc_q.size() - base == 3) begin
      check("lit_right", start_val_q[base],     {16'd180, 1'b0, 1'b1});
      check("lit_left",  start_val_q[base + 1], {16'd180, 1'b1, 1'b0});
      check("lit_uturn", start_val_q[base + 2], {16'd360, 1'b0, 1'b1});
    end

    // fill the queue, then abort mid-run
    resp_len = LONG_BUSY;
    for (int i = 0; i < 5; i++) push(2'd0, 16'(10 * (i + 1)));
    check("lit_full_level", level, 4);
    check("lit_full_ready", cmd_ready, 0);
    wait_start(s0);
    repeat (10) tick();
    check("lit_abort_pre_level", level, 3);
    check("lit_abort_pre_deg", degreeL, 20);
    abort = 1'b1;
    cmd_valid = 1'b1;
    tick();
    check("lit_abort_level", level, 0);
    check("lit_abort_deg", degreeL, 0);
    check("lit_abort_drv", driver_sel, 0);
    check("lit_abort_ready", cmd_ready, 0);
    repeat (3) tick();
    check("lit_abort_hold_level", level, 0);
    abort = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check("lit_abort_release_ready", cmd_ready, 1);
    n = 0;
    while (step_busy && n < 300) begin tick(); n++; end
    wait_idle();

    // controllers never respond: ARM window expires
    resp_en = 0;
    push(2'd0, 16'd0);
    push(2'd0, 16'd45);
    wait_start(s0);
    wait_start(s1);
    check("lit_arm_gap", s1 - s0, ARM + SETTLE + 2);
    check("lit_arm_deg", degreeL, 45);
    wait_idle();
    resp_en = 1;

    // stand-alone FIFO: push and pop together while full
    for (int i = 1; i <= 4; i++) begin
      f_wdata = 4'(i); f_push = 1'b1; tick();
    end
    f_push = 1'b0;
    check("lit_fifo_full", {f_full, f_level}, {1'b1, 3'd4});
    check("lit_fifo_head", f_rdata, 1);
    f_wdata = 4'd5; f_push = 1'b1; f_pop = 1'b1; tick();
    f_push = 1'b0; f_pop = 1'b0;
    check("lit_fifo_pp_level", f_level, 4);
    for (int i = 0; i < 4; i++) begin
      check("lit_fifo_order", f_rdata, 4'(i + 2));
      f_pop = 1'b1; tick(); f_pop = 1'b0;
    end
    check("lit_fifo_empty", f_empty, 1);

    // RUN watchdog
`ifdef MOVE_TIMEOUT_EN
    resp_len = 100;
    push(2'd0, 16'd10);
    push(2'd0, 16'd20);
    n = 0;
    while (!fault && n < 200) begin tick(); n++; end
    check("lit_tmo_fault", fault, 1);
    check("lit_tmo_level", level, 0);
    check("lit_tmo_drv", driver_sel, 0);
    repeat (20) tick();
    check("lit_tmo_sticky", fault, 1);
    n = 0;
    while (step_busy && n < 200) begin tick(); n++; end
`else
    check("lit_no_tmo_fault", fault, 0);
`endif
    rst_n = 1'b0;
    #1;
    check("lit_reset_fault", fault, 0);
    check("lit_reset_level2", level, 0);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge WF_CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
